// File: rtl/ahb_esram_slave.sv
// AHB-Lite eSRAM responder: OKAY data phases take WAIT_STATES+1 cycles, ERROR data phases take 2 cycles.
// HREADYOUT is low only in wait states and the first ERROR cycle. Address phases are taken only while HREADYOUT is high.
module ahb_esram_slave #(
  parameter int          ADDWID      = 14,
  parameter logic [15:0] BASE_HI     = 16'h2000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;
  localparam logic [2:0] WS_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  logic [31:0]       mem_q [0:(1 << ADDWID) - 1];
  logic [2:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDWID-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [31:0]       hrdata_q, hrdata_d;

  logic              slave_rdy;
  logic              accept;
  logic              acc_err;
  logic [ADDWID-1:0] acc_addr;
  logic [ADDWID-1:0] rd_addr;
  logic              load_rd;
  logic              fwd;
  logic              unused_htrans;

  assign unused_htrans = HTRANS[0];

  always_comb begin
    slave_rdy = (state_q != S_WAIT) && (state_q != S_ERR1);
    accept    = HSEL && HREADYIN && HTRANS[1] && slave_rdy;
    acc_addr  = HADDR[ADDWID+1:2];
    acc_err   = (HADDR[31:16] != BASE_HI) || (HADDR[1:0] != 2'b00) ||
                (HSIZE != 3'b010) || ((HADDR[15:0] >> (ADDWID + 2)) != 16'd0);

    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    hrdata_d = hrdata_q;
    rd_addr  = addr_q;
    load_rd  = 1'b0;

    case (state_q)
      S_WAIT: begin
        if (cnt_q == WS_LAST) begin
          state_d = S_DATA;
          cnt_d   = 3'd0;
          load_rd = !wr_q;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all complete this cycle, so a new address phase can start here.
        state_d = S_IDLE;
        if (accept) begin
          addr_d = acc_addr;
          wr_d   = HWRITE;
          if (acc_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 3'd0;
          end else begin
            state_d = S_DATA;
            rd_addr = acc_addr;
            load_rd = !HWRITE;
          end
        end
      end
    endcase

    // A write finishing this cycle has not reached the array yet; pass its data straight through.
    fwd = (state_q == S_DATA) && wr_q && (addr_q == rd_addr);
    if (load_rd) begin
      hrdata_d = fwd ? HWDATA : mem_q[rd_addr];
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      hrdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      hrdata_q <= hrdata_d;
    end
  end

  always_ff @(posedge mclk) begin
    if (!reset && (state_q == S_DATA) && wr_q) begin
      mem_q[addr_q] <= HWDATA;
    end
  end

  assign HREADYOUT = slave_rdy;
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_esram_slave.sv
// Directed bench for ahb_esram_slave: one instance with one wait state and one zero-wait instance.
// Each slave's HREADYIN is tied to its own HREADYOUT, as on a single-slave bus.
module tb_ahb_esram_slave;

  logic        clk;
  logic        reset;
  logic        hsel0, hsel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        rdy0, rdy1;
  logic        resp0, resp1;
  logic [31:0] hrdata0, hrdata1;
  int          total;
  int          bad;

  ahb_esram_slave #(.ADDWID(14), .BASE_HI(16'h2000), .WAIT_STATES(1)) u_dut (
    .mclk(clk), .reset(reset), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADYIN(rdy1),
    .HREADYOUT(rdy1), .HRDATA(hrdata1), .HRESP(resp1)
  );

  ahb_esram_slave #(.ADDWID(14), .BASE_HI(16'h2000), .WAIT_STATES(0)) u_dut0 (
    .mclk(clk), .reset(reset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADYIN(rdy0),
    .HREADYOUT(rdy0), .HRDATA(hrdata0), .HRESP(resp0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required earlier finish", $time);
    $fatal(1);
  end

  // One non-pipelined transfer on the selected slave; entered and left just after a rising edge.
  task automatic xfer(input bit which, input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int ncyc,
                      output logic [7:0] rdy_tr, output logic [7:0] resp_tr);
    logic r;
    if (which) hsel1 = 1'b1; else hsel0 = 1'b1;
    haddr = a; htrans = 2'b10; hwrite = w; hsize = sz;
    @(posedge clk); #1;
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wd;
    ncyc = 0; rdy_tr = '0; resp_tr = '0; rd = '0; r = 1'b0;
    while (!r && ncyc < 8) begin
      @(negedge clk);
      r = which ? rdy1 : rdy0;
      rdy_tr[ncyc]  = r;
      resp_tr[ncyc] = which ? resp1 : resp0;
      rd = which ? hrdata1 : hrdata0;
      ncyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hsel0 = 1'b0; hsel1 = 1'b0; haddr = '0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'b010; hwdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++; if (rdy1 !== 1'b1)  begin bad++; $display("FAIL rst_ready_ws1: got %b want 1", rdy1); end
    total++; if (resp1 !== 1'b0) begin bad++; $display("FAIL rst_resp_ws1: got %b want 0", resp1); end
    total++; if (hrdata1 !== 32'd0) begin bad++; $display("FAIL rst_rdata_ws1: got %h want 0", hrdata1); end
    total++; if (rdy0 !== 1'b1)  begin bad++; $display("FAIL rst_ready_ws0: got %b want 1", rdy0); end
    total++; if (resp0 !== 1'b0) begin bad++; $display("FAIL rst_resp_ws0: got %b want 0", resp0); end
    total++; if (hrdata0 !== 32'd0) begin bad++; $display("FAIL rst_rdata_ws0: got %h want 0", hrdata0); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; int n; logic [7:0] rt, pt;
    xfer(1'b1, 32'h2000_0010, 1'b1, 3'b010, 32'hDEAD_BEEF, rd, n, rt, pt);
    total++;
    if (n !== 2 || rt[1:0] !== 2'b10 || pt[1:0] !== 2'b00) begin
      bad++; $display("FAIL wr_phase: cycles=%0d rdy=%b resp=%b want 2/10/00", n, rt[1:0], pt[1:0]);
    end
    xfer(1'b1, 32'h2000_0010, 1'b0, 3'b010, 32'h0, rd, n, rt, pt);
    total++;
    if (n !== 2 || rt[1:0] !== 2'b10 || pt[1:0] !== 2'b00) begin
      bad++; $display("FAIL rd_phase: cycles=%0d rdy=%b resp=%b want 2/10/00", n, rt[1:0], pt[1:0]);
    end
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] tr; logic [31:0] rd;
    rd = '0;
    hsel1 = 1'b1; haddr = 32'h2000_0100; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    hwdata = 32'h1234_5678; hwrite = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tr[c] = rdy1;
      if (c == 3) rd = hrdata1;
      @(posedge clk); #1;
      if (c == 1) begin hsel1 = 1'b0; htrans = 2'b00; end
    end
    total++; if (tr !== 4'b1010) begin bad++; $display("FAIL b2b_ready: got %b want 1010", tr); end
    total++; if (rd !== 32'h1234_5678) begin bad++; $display("FAIL b2b_data: got %h want 12345678", rd); end

    hsel0 = 1'b1; haddr = 32'h2000_0200; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    hwdata = 32'hCAFE_F00D; hwrite = 1'b0;
    @(negedge clk);
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL fwd_wr_ready: got %b want 1", rdy0); end
    @(posedge clk); #1;
    hsel0 = 1'b0; htrans = 2'b00;
    @(negedge clk);
    total++;
    if (rdy0 !== 1'b1 || hrdata0 !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL fwd_rd: ready=%b data=%h want 1/cafef00d", rdy0, hrdata0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    logic [31:0] rd; int n; logic [7:0] rt, pt;
    logic [31:0] err_addr [3];
    logic [2:0]  err_size [3];
    logic [31:0] alias_addr [3];
    logic [31:0] pre [3];
    err_addr   = '{32'h4003_8080, 32'h2000_0030, 32'h2000_0002};
    err_size   = '{3'b010, 3'b001, 3'b010};
    alias_addr = '{32'h2000_8080, 32'h2000_0030, 32'h2000_0000};
    pre        = '{32'h0101_0101, 32'h3030_3030, 32'h00C0_FFEE};

    xfer(1'b1, 32'h4003_8080, 1'b0, 3'b010, 32'h0, rd, n, rt, pt);
    total++;
    if (n !== 2 || rt[1:0] !== 2'b10 || pt[1:0] !== 2'b11) begin
      bad++; $display("FAIL err_read: cycles=%0d rdy=%b resp=%b want 2/10/11", n, rt[1:0], pt[1:0]);
    end
    for (int i = 0; i < 3; i++) begin
      xfer(1'b1, alias_addr[i], 1'b1, 3'b010, pre[i], rd, n, rt, pt);
      xfer(1'b1, err_addr[i], 1'b1, err_size[i], 32'hFFFF_FFFF, rd, n, rt, pt);
      total++;
      if (n !== 2 || rt[1:0] !== 2'b10 || pt[1:0] !== 2'b11) begin
        bad++; $display("FAIL err_write%0d: cycles=%0d rdy=%b resp=%b want 2/10/11", i, n, rt[1:0], pt[1:0]);
      end
      xfer(1'b1, alias_addr[i], 1'b0, 3'b010, 32'h0, rd, n, rt, pt);
      total++;
      if (rd !== pre[i]) begin bad++; $display("FAIL err_alias%0d: got %h want %h", i, rd, pre[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; int n; logic [7:0] rt, pt;
    xfer(1'b1, 32'h2000_FFFC, 1'b1, 3'b010, 32'hA5A5_A5A5, rd, n, rt, pt);
    xfer(1'b1, 32'h2000_0000, 1'b1, 3'b010, 32'h5A5A_5A5A, rd, n, rt, pt);
    xfer(1'b1, 32'h2000_FFFC, 1'b0, 3'b010, 32'h0, rd, n, rt, pt);
    total++; if (rd !== 32'hA5A5_A5A5) begin bad++; $display("FAIL wrap_top: got %h want a5a5a5a5", rd); end
    xfer(1'b1, 32'h2000_0000, 1'b0, 3'b010, 32'h0, rd, n, rt, pt);
    total++; if (rd !== 32'h5A5A_5A5A) begin bad++; $display("FAIL wrap_zero: got %h want 5a5a5a5a", rd); end
  endtask

  task automatic test_zero_wait_stream();
    logic [31:0] exp;
    for (int n = 0; n <= 16; n++) begin
      if (n < 16) begin
        hsel0 = 1'b1; htrans = 2'b10; hsize = 3'b010;
        haddr = 32'h2000_0400 + 32'(4 * (n % 8));
        hwrite = (n < 8);
      end else begin
        hsel0 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
      end
      if (n >= 1 && n <= 8) hwdata = 32'hC0DE_0000 + 32'(n - 1) * 32'h0101;
      @(negedge clk);
      if (n >= 1) begin
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL stream_ready%0d: got %b want 1", n, rdy0); end
      end
      if (n >= 9) begin
        exp = 32'hC0DE_0000 + 32'(n - 9) * 32'h0101;
        total++; if (hrdata0 !== exp) begin bad++; $display("FAIL stream_data%0d: got %h want %h", n - 9, hrdata0, exp); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] rd; int n; logic [7:0] rt, pt;
    xfer(1'b1, 32'h2000_0020, 1'b1, 3'b010, 32'h1111_1111, rd, n, rt, pt);
    hsel1 = 1'b1; haddr = 32'h2000_0020; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h2222_2222;
    @(negedge clk);
    total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL rstmid_wait: ready=%b want 0", rdy1); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (rdy1 !== 1'b1 || resp1 !== 1'b0 || hrdata1 !== 32'd0) begin
      bad++; $display("FAIL rstmid_out: ready=%b resp=%b data=%h want 1/0/0", rdy1, resp1, hrdata1);
    end
    @(posedge clk); #1;
    xfer(1'b1, 32'h2000_0020, 1'b0, 3'b010, 32'h0, rd, n, rt, pt);
    total++; if (rd !== 32'h1111_1111) begin bad++; $display("FAIL rstmid_mem: got %h want 11111111", rd); end

    xfer(1'b0, 32'h2000_0040, 1'b1, 3'b010, 32'h4444_4444, rd, n, rt, pt);
    hsel0 = 1'b1; haddr = 32'h2000_0040; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
    @(posedge clk); #1;
    hsel0 = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h5555_5555; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    xfer(1'b0, 32'h2000_0040, 1'b0, 3'b010, 32'h0, rd, n, rt, pt);
    total++; if (rd !== 32'h4444_4444) begin bad++; $display("FAIL rstdata_mem: got %h want 44444444", rd); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_errors();
    test_wrap();
    test_zero_wait_stream();
    test_reset_mid_transfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_esram_slave.md
Name: ahb_esram_slave

Overview:
- AHB-Lite responder (slave) modelling the 64 KB eSRAM window at 0x2000_0000–0x2000_FFFF as a 16K x 32 word memory.
- Used as the bench and standalone-RTL counterpart for the FIFO-side AHB master.
- Accepts pipelined NONSEQ/SEQ word transfers with a configurable wait-state count.
- Returns two-cycle ERROR responses for illegal accesses.

Parameters:
- ADDWID, 14, word-address width; memory depth 2^ADDWID words.
- BASE_HI, 16'h2000, required HADDR[31:16] for a legal access.
- WAIT_STATES, 1, HREADYOUT-low cycles inserted per OKAY data phase (0–7).

Ports:
- mclk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- HSEL  input  1  slave select.
- HADDR  input  32  byte address.
- HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  transfer size; only 3'b010 (word) is legal.
- HWDATA  input  32  write data, valid in the data phase.
- HREADYIN  input  1  bus HREADY; an address phase is accepted only when it is high.
- HREADYOUT  output  1  data-phase completion.
- HRDATA  output  32  read data.
- HRESP  output  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (mclk edge with reset=1) gives: HREADYOUT=1, HRESP=0, HRDATA=0, state=S_IDLE, wait counter=0, pending transfer discarded. Memory contents are not cleared.
- Reset mid-transfer drops the transfer: no memory write occurs, and outputs go to reset values on the next edge.
- Address phase is accepted on an edge where HSEL & HREADYIN & HTRANS[1]. The slave latches addr=HADDR[ADDWID+1:2], the write flag, and an error flag.
- Error flag is set if any of these hold:
  - HADDR[31:16] != BASE_HI
  - HADDR[1:0] != 0
  - HSIZE != 3'b010
  - HADDR[15:ADDWID+2] != 0
- IDLE/BUSY or HSEL=0 with HREADYIN=1: slave stays or returns to S_IDLE with HREADYOUT=1, HRESP=0 (zero-wait OKAY).
- Address phases with HREADYIN=0 are ignored.
- State machine:
  - S_IDLE: on accept with error → S_ERR1. Otherwise → S_WAIT if WAIT_STATES>0, else → S_DATA.
  - S_WAIT: HREADYOUT=0, HRESP=0. The counter counts WAIT_STATES cycles, then → S_DATA.
  - S_DATA: HREADYOUT=1, HRESP=0; the transfer completes this cycle.
    - Write: HWDATA is written to mem[addr] at the end of this cycle.
    - Read: HRDATA = mem[addr] is valid during this cycle (registered, prepared in the last wait cycle or at accept when WAIT_STATES=0).
    - A new accept in the same cycle (pipelined) re-enters the state machine as from S_IDLE; otherwise → S_IDLE.
  - S_ERR1: HREADYOUT=0, HRESP=1 → S_ERR2.
  - S_ERR2: HREADYOUT=1, HRESP=1. No memory access. Any accepted address phase here is processed as from S_IDLE. Otherwise → S_IDLE.
- Latency: an OKAY data phase takes exactly WAIT_STATES+1 cycles; an ERROR data phase takes exactly 2 cycles.
- Read-after-write hazard: a read whose data phase immediately follows a write data phase to the same addr returns the just-written HWDATA (forwarded), never the stale word.
- HRDATA holds its last value outside read data phases, and holds its value during writes and errors.
- Address arithmetic: word addr wraps within ADDWID bits; 0x2000_FFFC maps to word 16383. No burst-boundary checks are made; SEQ is treated as NONSEQ.
- A simultaneous write data-phase completion and a new read accept to the same addr is handled by forwarding as above.

Test Plan:
- Reset, then single write 0x2000_0010 ← 0xDEADBEEF, then read 0x2000_0010 with WAIT_STATES=1 → write takes 2 cycles (HREADYOUT 0,1); read returns 0xDEADBEEF with HRESP=0.
- Back-to-back pipelined write 0x2000_0100 ← 0x12345678, then immediate read 0x2000_0100 → read returns 0x12345678 (forwarding); no extra idle cycle between the two data phases.
- Illegal accesses: read 0x4003_8080; write with HSIZE=3'b001; address 0x2000_0002 → each gives HREADYOUT 0 then 1 with HRESP=1 both cycles; memory at the aliased word is unchanged on readback.
- Wrap/boundary: write 0x2000_FFFC ← 0xA5A5A5A5 and 0x2000_0000 ← 0x5A5A5A5A, then read both → distinct values returned; word 16383 and word 0 are not aliased.
- WAIT_STATES=0 build: 8 consecutive NONSEQ writes then 8 reads, with HREADYOUT held 1 throughout → one transfer per cycle, data correct.
- Reset asserted during S_WAIT of a write to 0x2000_0020 (pre-loaded 0x11111111) → next cycle HREADYOUT=1, HRESP=0; readback gives 0x11111111.
